// File: rtl/usb_bus_state_monitor_if.sv
// Pad-side inputs and bus-condition flags of the USB bus state monitor.
// The monitor uses the slave modport; the pad driver or bench uses the master modport.
interface usb_bus_state_monitor_if;
  logic       dp_raw;
  logic       dm_raw;
  logic [1:0] line_state;
  logic       line_edge;
  logic       bus_reset;
  logic       bus_reset_start;
  logic       suspend;
  logic       resume;

  modport master (
    output dp_raw, dm_raw,
    input  line_state, line_edge, bus_reset, bus_reset_start, suspend, resume
  );

  modport slave (
    input  dp_raw, dm_raw,
    output line_state, line_edge, bus_reset, bus_reset_start, suspend, resume
  );
endinterface

// File: rtl/usb_bus_state_monitor.sv
// Full-speed USB bus-condition monitor: synchronises and glitch-filters D+/D-, and sequences
// the device ACTIVE/RESET/SUSPEND state from held SE0 (bus reset), idle J (suspend) and K (resume).
module usb_bus_state_monitor #(
  parameter int FILTER_CYCLES  = 2,
  parameter int RESET_CYCLES   = 120,
  parameter int SUSPEND_CYCLES = 144000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  usb_bus_state_monitor_if.slave  bus
);

  localparam int CW = $clog2(SUSPEND_CYCLES + 1);
  localparam int FW = $clog2(FILTER_CYCLES + 1);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'b00,
    ST_RESET   = 2'b01,
    ST_SUSPEND = 2'b10
  } state_t;

  logic [1:0]    sync1_reg, sync2_reg, prev_reg;
  logic [1:0]    line_state_reg, line_state_q_reg;
  logic          line_edge_reg;
  logic [FW-1:0] stable_cnt_reg, stable_run;
  logic          filter_accept;

  logic [CW-1:0] se0_cnt_reg, idle_cnt_reg;
  logic          is_se0, is_j, is_k, se0_hit, idle_hit;

  state_t        state_reg, state_next;
  logic          bus_reset_reg, bus_reset_start_reg, suspend_reg, resume_reg;
  logic          bus_reset_next, bus_reset_start_next, suspend_next, resume_next;

  // stable_run is how many consecutive cycles sync2 has shown its current value, saturating
  always_comb begin
    stable_run = FW'(1);
    if (sync2_reg == prev_reg) begin
      if (stable_cnt_reg >= FW'(FILTER_CYCLES))
        stable_run = FW'(FILTER_CYCLES);
      else
        stable_run = stable_cnt_reg + FW'(1);
    end
  end

  assign filter_accept = (stable_run >= FW'(FILTER_CYCLES)) && (sync2_reg != line_state_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg        <= LS_J;
      sync2_reg        <= LS_J;
      prev_reg         <= LS_J;
      stable_cnt_reg   <= '0;
      line_state_reg   <= LS_J;
      line_state_q_reg <= LS_J;
      line_edge_reg    <= 1'b0;
    end else begin
      sync1_reg        <= {bus.dp_raw, bus.dm_raw};
      sync2_reg        <= sync1_reg;
      prev_reg         <= sync2_reg;
      stable_cnt_reg   <= stable_run;
      if (filter_accept)
        line_state_reg <= sync2_reg;
      line_state_q_reg <= line_state_reg;
      line_edge_reg    <= (line_state_reg != line_state_q_reg);
    end
  end

  assign is_se0   = (line_state_reg == LS_SE0);
  assign is_j     = (line_state_reg == LS_J);
  assign is_k     = (line_state_reg == LS_K);
  assign se0_hit  = is_se0 && (se0_cnt_reg == CW'(RESET_CYCLES - 1));
  assign idle_hit = is_j && (idle_cnt_reg == CW'(SUSPEND_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      se0_cnt_reg  <= '0;
      idle_cnt_reg <= '0;
    end else begin
      if (!is_se0)
        se0_cnt_reg <= '0;
      else if (se0_cnt_reg != CW'(SUSPEND_CYCLES))
        se0_cnt_reg <= se0_cnt_reg + CW'(1);

      // leaving bus reset demands a fresh full idle period before suspend
      if (!is_j || (state_reg == ST_RESET && !is_se0))
        idle_cnt_reg <= '0;
      else if (idle_cnt_reg != CW'(SUSPEND_CYCLES))
        idle_cnt_reg <= idle_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= ST_ACTIVE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ACTIVE: begin
        if (se0_hit)
          state_next = ST_RESET;
        else if (idle_hit)
          state_next = ST_SUSPEND;
      end
      ST_RESET: begin
        if (!is_se0)
          state_next = ST_ACTIVE;
      end
      ST_SUSPEND: begin
        if (se0_hit)
          state_next = ST_RESET;
        else if (is_k)
          state_next = ST_ACTIVE;
      end
      default: state_next = ST_ACTIVE;
    endcase
  end

  always_comb begin
    bus_reset_next       = (state_next == ST_RESET);
    suspend_next         = (state_next == ST_SUSPEND);
    bus_reset_start_next = (state_reg != ST_RESET) && (state_next == ST_RESET);
    resume_next          = (state_reg == ST_SUSPEND) && (state_next == ST_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_reset_reg       <= 1'b0;
      bus_reset_start_reg <= 1'b0;
      suspend_reg         <= 1'b0;
      resume_reg          <= 1'b0;
    end else begin
      bus_reset_reg       <= bus_reset_next;
      bus_reset_start_reg <= bus_reset_start_next;
      suspend_reg         <= suspend_next;
      resume_reg          <= resume_next;
    end
  end

  assign bus.line_state      = line_state_reg;
  assign bus.line_edge       = line_edge_reg;
  assign bus.bus_reset       = bus_reset_reg;
  assign bus.bus_reset_start = bus_reset_start_reg;
  assign bus.suspend         = suspend_reg;
  assign bus.resume          = resume_reg;

endmodule

// File: tb/tb_usb_bus_state_monitor.sv
// Bench for usb_bus_state_monitor: directed bus scenarios followed by random line segments,
// every cycle compared against a run-length reference model of the bus rules.
module tb_usb_bus_state_monitor;

  localparam int F = 2;
  localparam int R = 8;
  localparam int S = 20;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  usb_bus_state_monitor_if bus_if ();

  usb_bus_state_monitor #(
    .FILTER_CYCLES  (F),
    .RESET_CYCLES   (R),
    .SUSPEND_CYCLES (S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc_no = 0;
  int n_edge, n_brs, n_res;

  // reference model: sync pipeline, window of synced samples, run lengths, device state
  logic [1:0] m_s1, m_s2, m_ls;
  logic [1:0] m_hist[$];
  bit         m_chg;
  int         m_se0, m_idle;
  int         m_state;   // 0 active, 1 bus reset, 2 suspended
  logic       e_edge, e_brs, e_br, e_susp, e_res;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc_no, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = J; m_s2 = J; m_ls = J;
    m_hist.delete();
    m_chg = 0; m_se0 = 0; m_idle = 0; m_state = 0;
    e_edge = 0; e_brs = 0; e_br = 0; e_susp = 0; e_res = 0;
  endtask

  task automatic model_edge(input logic [1:0] din);
    logic [1:0] v;
    bit acc;
    int se0_now, idle_now, nxt;
    v = m_s2;
    m_hist.push_back(v);
    if (m_hist.size() > F) void'(m_hist.pop_front());
    acc = (m_hist.size() == F) && (v != m_ls);
    foreach (m_hist[i]) if (m_hist[i] != v) acc = 0;
    se0_now  = (m_ls == SE0) ? m_se0 + 1 : 0;
    idle_now = (m_ls == J) ? m_idle + 1 : 0;
    nxt = m_state; e_brs = 0; e_res = 0;
    case (m_state)
      0: if (m_ls == SE0 && se0_now == R) begin nxt = 1; e_brs = 1; end
         else if (m_ls == J && idle_now == S) nxt = 2;
      1: if (m_ls != SE0) begin nxt = 0; idle_now = 0; end
      default: if (m_ls == SE0 && se0_now == R) begin nxt = 1; e_brs = 1; end
               else if (m_ls == K) begin nxt = 0; e_res = 1; end
    endcase
    m_state = nxt; m_se0 = se0_now; m_idle = idle_now;
    e_edge = m_chg; m_chg = acc;
    if (acc) m_ls = v;
    m_s2 = m_s1; m_s1 = din;
    e_br = (m_state == 1); e_susp = (m_state == 2);
  endtask

  // one clock cycle: called at a negedge, drives pads, checks all outputs after the posedge
  task automatic cyc(input logic [1:0] dpdm);
    bus_if.dp_raw = dpdm[1];
    bus_if.dm_raw = dpdm[0];
    @(posedge clk);
    model_edge(dpdm);
    cyc_no++;
    #1;
    chk("line_state", bus_if.line_state, m_ls);
    chk("line_edge", {1'b0, bus_if.line_edge}, {1'b0, e_edge});
    chk("bus_reset", {1'b0, bus_if.bus_reset}, {1'b0, e_br});
    chk("bus_reset_start", {1'b0, bus_if.bus_reset_start}, {1'b0, e_brs});
    chk("suspend", {1'b0, bus_if.suspend}, {1'b0, e_susp});
    chk("resume", {1'b0, bus_if.resume}, {1'b0, e_res});
    chk("flags_exclusive", {1'b0, bus_if.bus_reset & bus_if.suspend}, 2'b00);
    if (bus_if.line_edge) n_edge++;
    if (bus_if.bus_reset_start) n_brs++;
    if (bus_if.resume) n_res++;
    @(negedge clk);
  endtask

  task automatic seg(input logic [1:0] sym, input int len);
    $display("[TB] segment line=%b cycles=%0d", sym, len);
    for (int i = 0; i < len; i++) cyc(sym);
  endtask

  task automatic clear_counts();
    n_edge = 0; n_brs = 0; n_res = 0;
  endtask

  // asynchronous reset mid-cycle: outputs must clear before any clock edge
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_ls"}, bus_if.line_state, J);
    chk({tag, "_flags"}, {bus_if.line_edge, bus_if.bus_reset}, 2'b00);
    chk({tag, "_pulses"}, {bus_if.bus_reset_start, bus_if.resume}, 2'b00);
    chk({tag, "_susp"}, {1'b0, bus_if.suspend}, 2'b00);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] async reset %s released", tag);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.dp_raw = 1'b0;
    bus_if.dm_raw = 1'b0;
    model_reset();
    clear_counts();
    repeat (3) @(negedge clk);
    chk("rst_ls", bus_if.line_state, J);
    chk("rst_flags", {bus_if.bus_reset, bus_if.suspend}, 2'b00);
    chk("rst_pulses", {bus_if.bus_reset_start, bus_if.resume}, 2'b00);
    chk("rst_edge", {1'b0, bus_if.line_edge}, 2'b00);

    // SE0 on the pads from release: line_state follows exactly 4 cycles later
    rst_n = 1'b1;
    repeat (3) cyc(SE0);
    chk("lat_before", bus_if.line_state, J);
    cyc(SE0);
    chk("lat_at4", bus_if.line_state, SE0);
    cyc(SE0);
    chk("lat_edge", {1'b0, bus_if.line_edge}, 2'b01);
    cyc(SE0);
    seg(J, 8);

    // glitch filter
    clear_counts();
    seg(K, 1); seg(J, 8);
    chk("glitch1_edges", 2'(n_edge), 2'd0);
    clear_counts();
    seg(K, 3); seg(J, 8);
    chk("glitch3_edges", 2'(n_edge), 2'd2);

    // SE0 one cycle short of reset, then exactly long enough
    clear_counts();
    seg(SE0, 7); seg(J, 8);
    chk("se0_7_no_reset", 2'(n_brs), 2'd0);
    clear_counts();
    seg(SE0, 8); seg(J, 8);
    chk("se0_8_reset", 2'(n_brs), 2'd1);
    chk("reset_released", {1'b0, bus_if.bus_reset}, 2'b00);
    seg(J, 14);
    chk("no_early_suspend", {1'b0, bus_if.suspend}, 2'b00);
    seg(J, 6);
    chk("suspend_after_idle", {1'b0, bus_if.suspend}, 2'b01);

    // resume by K
    clear_counts();
    seg(K, 3); seg(J, 6);
    chk("resume_once", 2'(n_res), 2'd1);
    chk("resume_unsuspended", {1'b0, bus_if.suspend}, 2'b00);

    // bus reset out of suspend
    seg(J, 30);
    chk("suspend_again", {1'b0, bus_if.suspend}, 2'b01);
    clear_counts();
    seg(SE0, 10); seg(J, 8);
    chk("susp_reset_start", 2'(n_brs), 2'd1);
    chk("susp_reset_no_resume", 2'(n_res), 2'd0);

    // asynchronous reset while in RESET and while in SUSPEND
    seg(J, 30);
    seg(SE0, 14);
    chk("in_reset", {1'b0, bus_if.bus_reset}, 2'b01);
    async_reset("mid_reset");
    seg(J, 26);
    chk("in_suspend", {1'b0, bus_if.suspend}, 2'b01);
    async_reset("mid_suspend");
    clear_counts();
    seg(J, 6);
    chk("post_rst_pulses", 2'(n_brs + n_res), 2'd0);

    // random line segments against the reference model
    for (int n = 0; n < 80; n++) begin
      logic [1:0] sym;
      int len;
      sym = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: len = $urandom_range(1, 3);
        1: len = $urandom_range(4, 10);
        2: len = $urandom_range(6, 12);
        default: len = 26;
      endcase
      seg(sym, len);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
